// File: rtl/mips_reg_bank.sv
// rtl/mips_reg_bank.sv - 32-entry MIPS register file, two combinational read ports, one write port
module mips_reg_bank #(
    parameter int                DATA_W   = 32,
    parameter int                SP_INDEX = 29,
    parameter logic [DATA_W-1:0] SP_RESET = 227,
    parameter int                BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reg_write,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    // Register 0 has no storage; its reads are forced to zero below.
    logic [DATA_W-1:0] regs_q [1:31];
    logic [DATA_W-1:0] regs_d [1:31];

    always_comb begin
        regs_d = regs_q;
        if (reg_write && (write_reg != 5'd0)) begin
            regs_d[write_reg] = write_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Forwarding is suppressed while in reset so outputs track the reset contents.
    logic byp1, byp2;
    assign byp1 = (BYPASS != 0) && reset_n && reg_write && (write_reg == read_reg1);
    assign byp2 = (BYPASS != 0) && reset_n && reg_write && (write_reg == read_reg2);

    always_comb begin
        read_data1 = '0;
        if (read_reg1 != 5'd0) begin
            read_data1 = byp1 ? write_data : regs_q[read_reg1];
        end
    end

    always_comb begin
        read_data2 = '0;
        if (read_reg2 != 5'd0) begin
            read_data2 = byp2 ? write_data : regs_q[read_reg2];
        end
    end

endmodule

// File: tb/tb_mips_reg_bank.sv
// tb/tb_mips_reg_bank.sv - scoreboard bench for mips_reg_bank, forwarding and non-forwarding builds
module tb_mips_reg_bank;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        reg_write = 1'b0;
    logic [4:0]  read_reg1 = '0;
    logic [4:0]  read_reg2 = '0;
    logic [4:0]  write_reg = '0;
    logic [31:0] write_data = '0;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

    always #5 clk = ~clk;

    mips_reg_bank #(.DATA_W(32), .SP_INDEX(29), .SP_RESET(32'd227), .BYPASS(1)) u_byp (
        .clk(clk), .reset_n(reset_n), .reg_write(reg_write),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data),
        .read_data1(rd1_b), .read_data2(rd2_b)
    );

    mips_reg_bank #(.DATA_W(32), .SP_INDEX(29), .SP_RESET(32'd227), .BYPASS(0)) u_nob (
        .clk(clk), .reset_n(reset_n), .reg_write(reg_write),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data),
        .read_data1(rd1_n), .read_data2(rd2_n)
    );

    typedef struct {
        string       name;
        logic [31:0] e1b, e2b, e1n, e2n;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [32];
    int          tests = 0;
    int          fails = 0;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        model[29] = 32'd227;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && reset_n && reg_write && write_reg == a) return write_data;
        return model[a];
    endfunction

    task automatic step(input logic rn, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] r1,
                        input logic [4:0] r2, input string nm);
        exp_t e;
        @(posedge clk);
        if (reset_n && reg_write && write_reg != 5'd0) model[write_reg] = write_data;
        #1;
        reset_n = rn; reg_write = we; write_reg = wa; write_data = wd;
        read_reg1 = r1; read_reg2 = r2;
        if (!rn) model_reset();
        e.name = nm;
        e.e1b = exp_rd(r1, 1'b1); e.e2b = exp_rd(r2, 1'b1);
        e.e1n = exp_rd(r1, 1'b0); e.e2n = exp_rd(r2, 1'b0);
        sb_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.name, ".byp.rd1"}, rd1_b, e.e1b);
            chk({e.name, ".byp.rd2"}, rd2_b, e.e2b);
            chk({e.name, ".nob.rd1"}, rd1_n, e.e1n);
            chk({e.name, ".nob.rd2"}, rd2_n, e.e2n);
        end
    end

    initial begin
        logic [4:0]  wa, r1, r2;
        logic [31:0] wd;
        logic        we, rn;
        model_reset();
        step(1'b1, 1'b0, 5'd0, 32'd0, 5'd29, 5'd5, "release");
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd29, 5'd5, "async_reset");
        step(1'b1, 1'b0, 5'd0, 32'd0, 5'd29, 5'd5, "after_reset");

        step(1'b1, 1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd0, "write8");
        step(1'b1, 1'b0, 5'd8, 32'h12345678, 5'd8, 5'd8, "hold8");
        step(1'b1, 1'b0, 5'd8, 32'h12345678, 5'd8, 5'd8, "hold8b");

        step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "zero_wr");
        step(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "zero_rd");

        step(1'b1, 1'b1, 5'd17, 32'h42, 5'd17, 5'd17, "bypass17");
        step(1'b1, 1'b0, 5'd17, 32'h0, 5'd17, 5'd17, "after17");

        step(1'b1, 1'b1, 5'd3, 32'h55, 5'd3, 5'd29, "wr3");
        step(1'b0, 1'b1, 5'd3, 32'hAA, 5'd3, 5'd29, "rst_wr3");
        step(1'b0, 1'b1, 5'd3, 32'hAA, 5'd3, 5'd29, "rst_hold3");
        step(1'b1, 1'b1, 5'd3, 32'h99, 5'd3, 5'd29, "rel_wr3");
        step(1'b1, 1'b0, 5'd3, 32'h0, 5'd3, 5'd29, "rd3");

        for (int i = 1; i < 32; i++)
            step(1'b1, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'(i - 1), "sweep_wr");
        for (int i = 0; i < 32; i++)
            step(1'b1, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), "sweep_rd");

        for (int n = 0; n < 400; n++) begin
            rn = ($urandom_range(0, 49) != 0);
            we = $urandom_range(0, 3) != 0;
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            r1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            step(rn, we, wa, wd, r1, r2, "rand");
        end

        step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "drain");
        @(posedge clk);
        @(posedge clk);
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
